// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared FSM encoding, default parameters and address decode for dm_resp
package mips_mem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  localparam int WAIT_CYC_DEF = 2;
  localparam int AW_DEF = 10;
  localparam int BYTE_OFF_W = 2;
  localparam int CNT_W = 4;
  function automatic logic addr_ok(input logic [31:0] a, input int aw);
    return a[BYTE_OFF_W-1:0] == '0 && (a >> (aw + BYTE_OFF_W)) == '0;
  endfunction
endpackage

// File: rtl/dm_if.sv
// dm_if: request/response handshake bundle between an initiator and dm_resp
interface dm_if;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0] req_be;
  logic resp_valid;
  logic resp_ready;
  logic [31:0] resp_rdata;
  logic resp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_array.sv
// dm_array: 2**AW x 32 storage with per-byte synchronous write and asynchronous read
module dm_array #(
  parameter int AW = 10
) (
  input logic clk,
  input logic we_i,
  input logic [3:0] be_i,
  input logic [AW-1:0] addr_i,
  input logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [31:0] mem_q [2**AW];
  // byte-lane write; contents are never cleared
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/dm_resp.sv
// dm_resp: data-memory responder returning each request after a fixed number of wait cycles
module dm_resp
  import mips_mem_pkg::*;
#(
  parameter int WAIT_CYC = WAIT_CYC_DEF,
  parameter int AW = AW_DEF
) (
  input logic clk,
  input logic rst,
  dm_if.slave bus
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] be_q;
  logic [31:0] rdata_q;
  logic err_q;
  logic idle, hs, go_resp, cur_we, cur_err, arr_we;
  logic [31:0] cur_addr, cur_wdata, arr_rdata;
  logic [3:0] cur_be;
  // with WAIT_CYC==0 the access happens on the handshake edge, so IDLE uses the live request
  always_comb begin
    idle = state_q == S_IDLE;
    hs = idle && bus.req_valid;
    cur_we = idle ? bus.req_we : we_q;
    cur_addr = idle ? bus.req_addr : addr_q;
    cur_wdata = idle ? bus.req_wdata : wdata_q;
    cur_be = idle ? bus.req_be : be_q;
    cur_err = !addr_ok(cur_addr, AW);
    go_resp = (hs && WAIT_CYC == 0) || (state_q == S_WAIT && cnt_q == CNT_W'(1));
    arr_we = go_resp && cur_we && !cur_err && !rst;
  end
  // next state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (hs) begin
      state_d = WAIT_CYC == 0 ? S_RESP : S_WAIT;
      cnt_d = CNT_W'(WAIT_CYC);
    end
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
      state_d = cnt_q == CNT_W'(1) ? S_RESP : S_WAIT;
    end
    if (state_q == S_RESP && bus.resp_ready) state_d = S_IDLE;
  end
  // state, counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (go_resp) begin
        rdata_q <= (cur_we || cur_err) ? '0 : arr_rdata;
        err_q <= cur_err;
      end
    end
  end
  // request latches so later bus changes cannot disturb the transaction in flight
  always_ff @(posedge clk) begin
    if (hs) begin
      we_q <= bus.req_we;
      addr_q <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      be_q <= bus.req_be;
    end
  end
  dm_array #(.AW(AW)) u_array (
    .clk(clk),
    .we_i(arr_we),
    .be_i(cur_be),
    .addr_i(cur_addr[AW+1:2]),
    .wdata_i(cur_wdata),
    .rdata_o(arr_rdata)
  );
  assign bus.req_ready = idle && !rst;
  assign bus.resp_valid = state_q == S_RESP && !rst;
  assign bus.resp_rdata = rst ? '0 : rdata_q;
  assign bus.resp_err = err_q && !rst;
endmodule

// File: tb/tb_dm_resp.sv
// tb_dm_resp: self-checking bench for dm_resp (WAIT_CYC=2 and WAIT_CYC=0 instances)
module tb_dm_resp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dm_if a_if ();
  dm_if z_if ();
  dm_resp #(.WAIT_CYC(2), .AW(10)) dut (.clk(clk), .rst(rst), .bus(a_if));
  dm_resp #(.WAIT_CYC(0), .AW(10)) dut0 (.clk(clk), .rst(rst), .bus(z_if));

  typedef struct {
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
    logic [31:0] exp_rd;
    logic exp_err;
  } vec_t;
  vec_t tbl [14];
  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] be,
                     input logic rr, output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    @(negedge clk);
    a_if.req_valid = 1'b1;
    a_if.req_we = we;
    a_if.req_addr = ad;
    a_if.req_wdata = wd;
    a_if.req_be = be;
    a_if.resp_ready = rr;
    while (!a_if.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("req_ready_timeout", 0, 1);
    @(negedge clk);
    a_if.req_valid = 1'b0;
    a_if.req_we = ~we;
    a_if.req_addr = $urandom;
    a_if.req_wdata = $urandom;
    a_if.req_be = 4'($urandom);
    lat = 1;
    while (!a_if.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = a_if.resp_rdata;
    er = a_if.resp_err;
  endtask

  initial begin #500000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    logic [31:0] rd, d, ad, m, exp_rd;
    logic er, bad, we;
    logic [3:0] be;
    int lat, n, w, sel;
    tbl[0]  = '{1'b1, 32'h10,   32'h1234_5678, 4'hF, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 32'h10,   32'h0,         4'hF, 32'h1234_5678, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,   32'hAABB_CCDD, 4'hF, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 32'h20,   32'h0000_00EE, 4'h1, 32'h0,         1'b0};
    tbl[4]  = '{1'b0, 32'h20,   32'h0,         4'hF, 32'hAABB_CCEE, 1'b0};
    tbl[5]  = '{1'b0, 32'h2,    32'h0,         4'hF, 32'h0,         1'b1};
    tbl[6]  = '{1'b0, 32'h1000, 32'h0,         4'hF, 32'h0,         1'b1};
    tbl[7]  = '{1'b0, 32'h10,   32'h0,         4'hF, 32'h1234_5678, 1'b0};
    tbl[8]  = '{1'b0, 32'h20,   32'h0,         4'hF, 32'hAABB_CCEE, 1'b0};
    tbl[9]  = '{1'b1, 32'h30,   32'h0BAD_0030, 4'hF, 32'h0,         1'b0};
    tbl[10] = '{1'b1, 32'h30,   32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    tbl[11] = '{1'b0, 32'h30,   32'h0,         4'h0, 32'h0BAD_0030, 1'b0};
    tbl[12] = '{1'b1, 32'h1032, 32'h5555_5555, 4'hF, 32'h0,         1'b1};
    tbl[13] = '{1'b0, 32'h30,   32'h0,         4'h5, 32'h0BAD_0030, 1'b0};
    {a_if.req_valid, a_if.req_we, a_if.req_addr, a_if.req_wdata, a_if.req_be, a_if.resp_ready} = '0;
    {z_if.req_valid, z_if.req_we, z_if.req_addr, z_if.req_wdata, z_if.req_be, z_if.resp_ready} = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", a_if.req_ready, 0);
    chk("rst_resp_valid", a_if.resp_valid, 0);
    chk("rst_rdata", a_if.resp_rdata, 0);
    chk("rst_err", a_if.resp_err, 0);
    chk("rst0_req_ready", z_if.req_ready, 0);
    chk("rst0_resp_valid", z_if.resp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", a_if.req_ready, 1);
    chk("rel0_req_ready", z_if.req_ready, 1);
    for (int i = 0; i < 14; i++) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 1'b1, rd, er, lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_lat", i), lat, 3);
    end
    // stalled response
    txn(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, er, lat);
    chk("s4_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      chk("s4_valid", a_if.resp_valid, 1);
      chk("s4_rdata", a_if.resp_rdata, 32'h1234_5678);
      chk("s4_req_ready", a_if.req_ready, 0);
      a_if.req_addr = $urandom;
      @(negedge clk);
    end
    a_if.resp_ready = 1'b1;
    @(negedge clk);
    chk("s4_done_valid", a_if.resp_valid, 0);
    chk("s4_done_ready", a_if.req_ready, 1);
    // reset one cycle after a write handshake
    @(negedge clk);
    {a_if.req_valid, a_if.req_we, a_if.req_addr, a_if.req_wdata, a_if.req_be} = {1'b1, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'hF};
    n = 0;
    while (!a_if.req_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    a_if.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("s5_rst_ready", a_if.req_ready, 0);
    chk("s5_rst_valid", a_if.resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s5_rel_ready", a_if.req_ready, 1);
    chk("s5_rel_valid", a_if.resp_valid, 0);
    txn(1'b0, 32'h30, 32'h0, 4'hF, 1'b1, rd, er, lat);
    chk("s5_read", rd, 32'h0BAD_0030);
    // reset during response keeps committed write
    txn(1'b1, 32'h34, 32'h5A5A_5A5A, 4'hF, 1'b0, rd, er, lat);
    rst = 1'b1;
    @(negedge clk);
    chk("rresp_valid", a_if.resp_valid, 0);
    rst = 1'b0;
    txn(1'b0, 32'h34, 32'h0, 4'hF, 1'b1, rd, er, lat);
    chk("rresp_read", rd, 32'h5A5A_5A5A);
    // zero-wait back-to-back traffic
    @(negedge clk);
    {z_if.req_valid, z_if.req_we, z_if.req_addr, z_if.req_wdata, z_if.req_be, z_if.resp_ready} =
      {1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b1};
    for (int k = 0; k < 10; k++) begin
      if (k == 4) z_if.req_we = 1'b0;
      chk($sformatf("s6_ready%0d", k), z_if.req_ready, k % 2 == 0);
      chk($sformatf("s6_valid%0d", k), z_if.resp_valid, k % 2 == 1);
      if (k % 2 == 1) chk($sformatf("s6_rdata%0d", k), z_if.resp_rdata, k < 4 ? 32'h0 : 32'hCAFE_F00D);
      @(negedge clk);
    end
    z_if.req_valid = 1'b0;
    // randomized traffic against a word-level model
    for (int i = 0; i < 8; i++) begin
      mdl[i] = $urandom;
      txn(1'b1, 32'h200 + 32'(4 * i), mdl[i], 4'hF, 1'b1, rd, er, lat);
    end
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      w = $urandom_range(0, 7);
      ad = 32'h200 + 32'(4 * w);
      if (sel == 8) ad = ad | 32'($urandom_range(1, 3));
      if (sel == 9) ad = ad | (32'($urandom_range(1, 1023)) << 12);
      we = 1'($urandom);
      be = 4'($urandom);
      d = $urandom;
      bad = (ad % 4 != 0) || (ad >= 32'd4096);
      exp_rd = (bad || we) ? 32'h0 : mdl[w];
      if (!bad && we) begin
        m = 0;
        for (int b = 0; b < 4; b++) if (be[b]) m = m | (32'hFF << (8 * b));
        mdl[w] = (mdl[w] & ~m) | (d & m);
      end
      txn(we, ad, d, be, 1'b1, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, bad});
      chk($sformatf("rnd%0d_lat", i), lat, 3);
    end
    for (int i = 0; i < 8; i++) begin
      txn(1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'h0, 1'b1, rd, er, lat);
      chk($sformatf("final%0d", i), rd, mdl[i]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 Parameter WAIT_CYC, default 2, SHALL set the number of wait cycles between request acceptance and response (legal range 0..15).
REQ-002 Parameter AW, default 10, SHALL set the word-address width; storage depth is 2**AW 32-bit words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 req_valid  input  1  SHALL mean the initiator presents a request.
REQ-006 req_ready  output  1  SHALL mean the block accepts a request this cycle.
REQ-007 req_we  input  1  SHALL select write (1) or read (0).
REQ-008 req_addr  input  32  SHALL be the byte address; bits [AW+1:2] select the word.
REQ-009 req_wdata  input  32  SHALL be the write data.
REQ-010 req_be  input  4  SHALL be the byte-lane write enables; bit i covers bits [8i+7:8i].
REQ-011 resp_valid  output  1  SHALL mean a response is presented.
REQ-012 resp_ready  input  1  SHALL mean the initiator consumes the response.
REQ-013 resp_rdata  output  32  SHALL carry the read data.
REQ-014 resp_err  output  1  SHALL flag a rejected request.

Function
REQ-015 The block SHALL implement the states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a handshake SHALL occur on req_valid&&req_ready at a rising edge.
REQ-017 On handshake, the block SHALL latch we, addr, wdata and be, load the wait counter with WAIT_CYC, and enter WAIT, or RESP when WAIT_CYC==0.
REQ-018 In WAIT, the counter SHALL decrement each cycle, and the block SHALL enter RESP on the edge where the counter equals 1.
REQ-019 resp_valid SHALL first be high exactly WAIT_CYC+1 cycles after the handshake edge.
REQ-020 The array write and the read-data capture SHALL occur on the edge entering RESP.
REQ-021 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_valid&&resp_ready, after which the block SHALL enter IDLE.
REQ-022 The block SHALL not accept a new request in the same cycle a response completes; minimum turnaround is WAIT_CYC+2 cycles.
REQ-023 A write SHALL update only the lanes with req_be set; be=4'b0000 SHALL be a no-op that still returns a response; resp_rdata SHALL be 0 for writes.
REQ-024 A read SHALL ignore be and return the full word.
REQ-025 A request with addr[1:0]!=0 or addr[31:AW+2]!=0 SHALL not access the array and SHALL respond with resp_err=1 and resp_rdata=0.
REQ-026 A read following a write to the same word SHALL return the written data.
REQ-027 Input changes on req_* lines after the handshake SHALL not affect the transaction in flight.

Reset
REQ-028 While rst=1, the block SHALL force state IDLE, counter 0, req_ready=0, resp_valid=0, resp_rdata=0 and resp_err=0; req_ready SHALL rise the first cycle after rst falls.
REQ-029 Reset during WAIT SHALL abandon the transaction, and no array write SHALL occur.
REQ-030 Reset during RESP SHALL drop the response; an array write already committed SHALL persist.
REQ-031 Array contents SHALL not be cleared by reset.

Structure
REQ-032 State encodings, the WAIT_CYC default and the address-field widths SHALL live in the shared package mips_mem_pkg.
REQ-033 Storage SHALL be a sub-module dm_array, with a 2**AW x 32 array, per-byte synchronous write and asynchronous read.
REQ-034 The FSM, counter, latches and error decode SHALL reside in dm_resp.

Verification
REQ-035 Scenario 1: write 0x1234_5678 to addr 0x10 with be=1111, then read 0x10 with WAIT_CYC=2 -> resp_valid 3 cycles after each handshake; read data = 0x1234_5678, err=0.
REQ-036 Scenario 2: write 0xAABB_CCDD to 0x20 with be=1111, then write 0x0000_00EE with be=0001, then read 0x20 -> 0xAABB_CCEE.
REQ-037 Scenario 3: read addr 0x0000_0002, then read addr 0x0000_1000 -> each response has err=1 and rdata=0, and the array is unchanged.
REQ-038 Scenario 4: hold resp_ready=0 for 5 cycles on a read of 0x10 -> resp_valid and rdata stay stable and req_ready stays 0; resp_ready=1 -> IDLE next cycle.
REQ-039 Scenario 5: assert rst one cycle after a write handshake to 0x30 with data 0xFFFF_FFFF -> no response; a later read of 0x30 returns the prior value.
REQ-040 Scenario 6: WAIT_CYC=0, with back-to-back req_valid and resp_ready held at 1 -> one transaction every 2 cycles, each response 1 cycle after its handshake.
